// File: rtl/led_pkg.sv
// Shared constants and types for the LED PWM fade stage.
package led_pkg;

  localparam int LED_N           = 4;
  localparam int PL_CLK_HZ       = 50_000_000;
  localparam int PWM_BITS_DEF    = 8;
  localparam int STEP_CYCLES_DEF = 48_828;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: target register, fading level, period-aligned duty shadow and PWM compare.
// Define LED_FADE_GAMMA_EN to load duty with (level*level) >> PWM_BITS instead of level.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_bit,
  input  logic                fade_en,
  input  logic                tick,
  input  logic                load_duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out,
  output logic                mismatch
);

  localparam int LW = PWM_BITS + 1;
  localparam logic [LW-1:0] FULL = {1'b1, {PWM_BITS{1'b0}}};

  logic          target_q, target_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] duty_q, duty_d;
  logic          led_out_q, led_out_d;
  logic [LW-1:0] goal;
  logic [LW-1:0] shaped;
  dir_e          dir;

`ifdef LED_FADE_GAMMA_EN
  logic [2*LW-1:0] level_sq;
  always_comb begin
    level_sq = {{LW{1'b0}}, level_q} * {{LW{1'b0}}, level_q};
    shaped   = level_sq[PWM_BITS +: LW];
  end
`else
  assign shaped = level_q;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    target_d  = led_bit;
    goal      = target_q ? FULL : '0;
    dir       = DIR_HOLD;
    level_d   = level_q;
    duty_d    = duty_q;
    led_out_d = ({1'b0, pwm_cnt} < duty_q);

    if (level_q < goal)      dir = DIR_UP;
    else if (level_q > goal) dir = DIR_DOWN;

    if (!fade_en) begin
      level_d = goal;
    end else if (tick) begin
      case (dir)
        DIR_UP:   level_d = level_q + 1'b1;
        DIR_DOWN: level_d = level_q - 1'b1;
        default:  level_d = level_q;
      endcase
    end

    // Duty only changes on the last count of a period, so a period is never cut short.
    if (load_duty) duty_d = shaped;
  end

  assign mismatch = (level_q != goal);
  assign led_out  = led_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q  <= 1'b0;
      level_q   <= '0;
      duty_q    <= '0;
      led_out_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      target_q  <= target_d;
      level_q   <= level_d;
      duty_q    <= duty_d;
      led_out_q <= led_out_d;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// Four-channel LED PWM driver with smooth fade between off and full brightness.
// Define LED_FADE_GAMMA_EN for square-law (perceptual) duty mapping in each channel.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_N-1:0] led_in,
  input  logic             fade_en,
  output logic [LED_N-1:0] led_out,
  output logic             busy
);

  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                tick;
  logic                load_duty;
  logic [LED_N-1:0]    mismatch;

  always_comb begin
    tick       = (tick_cnt_q == TW'(STEP_CYCLES - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    load_duty  = &pwm_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else begin
      pwm_cnt_q  <= pwm_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  for (genvar i = 0; i < LED_N; i++) begin : g_ch
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .led_bit   (led_in[i]),
      .fade_en   (fade_en),
      .tick      (tick),
      .load_duty (load_duty),
      .pwm_cnt   (pwm_cnt_q),
      .led_out   (led_out[i]),
      .mismatch  (mismatch[i])
    );
  end

  assign busy = |mismatch;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomized and directed bench for led_fade_pwm with PWM_BITS=3, STEP_CYCLES=4,
// compared cycle by cycle against an arithmetic model of fade, duty and PWM behaviour.
module tb_led_fade_pwm;

  localparam int PB   = 3;
  localparam int SC   = 4;
  localparam int FULL = 8;
`ifdef LED_FADE_GAMMA_EN
  localparam logic [7:0] SHAPE4 = 8'b0000_0011;
`else
  localparam logic [7:0] SHAPE4 = 8'b0000_1111;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] led_in = 4'h0;
  logic       fade_en = 1'b0;
  logic [3:0] led_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference state: edges since reset release, and per-channel target/level/duty/pin.
  int m_n;
  int m_target[4];
  int m_level[4];
  int m_duty[4];
  int m_out[4];

  led_fade_pwm #(
    .PWM_BITS    (PB),
    .STEP_CYCLES (SC)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .led_in  (led_in),
    .fade_en (fade_en),
    .led_out (led_out),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int goal_of(input int i);
    return (m_target[i] != 0) ? FULL : 0;
  endfunction

  function automatic int shape(input int lvl);
`ifdef LED_FADE_GAMMA_EN
    return (lvl * lvl) / FULL;
`else
    return lvl;
`endif
  endfunction

  function automatic void model_reset();
    m_n = 0;
    for (int i = 0; i < 4; i++) begin
      m_target[i] = 0;
      m_level[i]  = 0;
      m_duty[i]   = 0;
      m_out[i]    = 0;
    end
  endfunction

  // One clock edge: everything on the right-hand side is the state before the edge.
  function automatic void model_edge(input logic [3:0] li, input logic fe);
    int  phase;
    bit  tick;
    phase = m_n % FULL;
    tick  = ((m_n % SC) == SC - 1);
    for (int i = 0; i < 4; i++) begin
      m_out[i] = (phase < m_duty[i]) ? 1 : 0;
      if (phase == FULL - 1) m_duty[i] = shape(m_level[i]);
      if (!fe)                                   m_level[i] = goal_of(i);
      else if (tick && m_level[i] < goal_of(i))  m_level[i] = m_level[i] + 1;
      else if (tick && m_level[i] > goal_of(i))  m_level[i] = m_level[i] - 1;
      m_target[i] = li[i] ? 1 : 0;
    end
    m_n++;
  endfunction

  function automatic int model_busy();
    int b = 0;
    for (int i = 0; i < 4; i++) if (m_level[i] != goal_of(i)) b = 1;
    return b;
  endfunction

  function automatic int model_out();
    int v = 0;
    for (int i = 0; i < 4; i++) v = v | (m_out[i] << i);
    return v;
  endfunction

  task automatic compare(input string tag);
    check({tag, "_led_out"}, led_out, model_out());
    check({tag, "_busy"}, busy, model_busy());
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic cycle(input logic [3:0] li, input logic fe, input string tag);
    led_in  = li;
    fade_en = fe;
    @(posedge clk);
    model_edge(li, fe);
    @(negedge clk);
    compare(tag);
  endtask

  // Called at a negedge; reset lands mid-cycle and must clear outputs at once.
  task automatic async_reset(input string tag);
    #2;
    rst_n  = 1'b0;
    led_in = 4'hF;
    model_reset();
    #1;
    compare({tag, "_now"});
    @(negedge clk);
    compare({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    logic [7:0] pat;
    logic [3:0] li;
    logic       fe;

    rst_n   = 1'b0;
    led_in  = 4'hF;
    fade_en = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check("reset_led_out", led_out, 0);
      check("reset_busy", busy, 0);
    end
    rst_n = 1'b1;

    // Fade in channel 0 straight after reset release.
    cycle(4'b0001, 1'b1, "fadein");
    check("fadein_busy_rise", busy, 1);
    n = 1;
    while (busy && n < 100) begin
      cycle(4'b0001, 1'b1, "fadein");
      n++;
    end
    check("fadein_cycles", n, 32);
    while (m_n < 41) cycle(4'b0001, 1'b1, "fadein");
    repeat (8) begin
      cycle(4'b0001, 1'b1, "fadein_hold");
      check("fadein_full", led_out[0], 1);
    end

    // Snap channel 2 on from a random PWM phase.
    async_reset("snap_rst");
    repeat ($urandom_range(0, 7)) cycle(4'b0000, 1'b0, "snap_idle");
    n = 0;
    do begin
      cycle(4'b0100, 1'b0, "snap");
      n++;
    end while (led_out[2] !== 1'b1 && n < 20);
    check("snap_within_11", (n <= 11) ? 1 : 0, 1);
    repeat (16) begin
      cycle(4'b0100, 1'b0, "snap_hold");
      check("snap_on", led_out[2], 1);
      check("snap_busy", busy, 0);
    end

    // Reverse channel 1 mid-ramp.
    async_reset("rev_rst");
    n = 0;
    while (m_level[1] != 3 && n < 40) begin
      cycle(4'b0010, 1'b1, "rev_up");
      n++;
    end
    check("rev_reach3", (n < 40) ? 1 : 0, 1);
    cycle(4'b0000, 1'b1, "rev_drop");
    check("rev_busy", busy, 1);
    repeat (20) cycle(4'b0000, 1'b1, "rev_down");
    check("rev_settled", busy, 0);

    // Duty shape for level 4: phase chosen so the duty load samples level 4.
    async_reset("shape_rst");
    repeat (4) cycle(4'b0000, 1'b1, "shape_idle");
    while (m_n < 24) cycle(4'b0001, 1'b1, "shape_ramp");
    pat = '0;
    for (int j = 0; j < 8; j++) begin
      cycle(4'b0001, 1'b1, "shape");
      pat[j] = led_out[0];
    end
    check("duty_shape", pat, SHAPE4);

    // Reset mid-ramp at level 5, then the ramp restarts dark.
    async_reset("mid_rst0");
    n = 0;
    while (m_level[0] != 5 && n < 60) begin
      cycle(4'hF, 1'b1, "mid_ramp");
      n++;
    end
    check("mid_reach5", (n < 60) ? 1 : 0, 1);
    check("mid_busy", busy, 1);
    async_reset("mid_rst");
    check("mid_rst_led_out", led_out, 0);
    check("mid_rst_busy", busy, 0);
    repeat (8) begin
      cycle(4'hF, 1'b1, "restart");
      check("restart_dark", led_out, 0);
    end

    // Random patterns, fade modes and occasional asynchronous resets.
    repeat (80) begin
      if ($urandom_range(0, 15) == 0) async_reset("rand_rst");
      li = 4'($urandom);
      fe = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 48)) cycle(li, fe, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Downstream stage of the LED streaming pattern generator. Takes the 4-bit on/off LED pattern and drives the four physical LED pins with PWM. Each LED fades smoothly between off and full brightness instead of switching hard. Sits between the pattern generator output and the board LED pins in the 50 MHz PL clock domain.

## Interface
- `PWM_BITS`, 8: PWM resolution; one PWM period is 2^PWM_BITS clk cycles (256 cycles ≈ 195 kHz).
- `STEP_CYCLES`, 48_828: clk cycles per brightness step; a full fade takes 2^PWM_BITS steps (≈0.25 s).
- `clk`  input  1  PL clock, 50 MHz.
- `rst_n`  input  1  asynchronous, active-low reset.
- `led_in`  input  4  target pattern from the pattern generator; 1 = on, 0 = off.
- `fade_en`  input  1  1 = ramp brightness; 0 = snap to target.
- `led_out`  output  4  PWM drive to the LEDs; 1 = lit.
- `busy`  output  1  high while any channel's level differs from its target.

## Operation
- `led_in` is registered into `target[3:0]` every cycle.
- Per channel:
  - `level` is PWM_BITS+1 bits wide, range 0..FULL, where FULL = 2^PWM_BITS.
  - Goal is FULL when the target bit is 1, and 0 otherwise.
- The tick counter counts 0..STEP_CYCLES-1 and wraps; `tick` is asserted on the wrap cycle.
- With `fade_en`=1, on a tick each channel's level moves by ±1 toward its goal. When level equals the goal it holds; it never over- or under-shoots.
- With `fade_en`=0, level is loaded with the goal every cycle, independent of tick.
- A target change mid-ramp reverses direction at the next tick. There is no jump.
- The PWM counter `pwm_cnt` (PWM_BITS bits) free-runs and wraps from FULL-1 to 0.
- Shadow `duty` is loaded from level (or its gamma-mapped value) only when `pwm_cnt` = FULL-1. This keeps duty glitch-free within a period.
- `led_out[i]` is registered as `pwm_cnt < duty[i]` (compare extended to PWM_BITS+1 bits):
  - duty 0 gives constant off.
  - duty FULL gives constant on.
  - duty k gives k high cycles per period.
- `busy` is combinational: OR over channels of (level ≠ goal).
- `fade_en` may toggle at any time. It takes effect on the next cycle.

## Timing
- Reset values, applied immediately on `rst_n` low: `target`, `level`, `duty`, `pwm_cnt`, tick counter and `led_out` are all 0, and `busy`=0.
- The first tick occurs STEP_CYCLES cycles after reset release.
- Latency, `led_in` edge → `busy`: 1 cycle, when fade_en=1 and the goal changes.
- Latency, `led_in` edge → `level` (fade_en=0): 2 cycles.
- `duty` update: at the first `pwm_cnt`=FULL-1 after `level` changes.
- `led_out` reflects the new duty starting from the cycle after `pwm_cnt` wraps to 0.
- Worst-case pattern-to-pin latency with fade_en=0 is FULL+3 cycles.
- A full fade-in with fade_en=1 from level 0 takes FULL×STEP_CYCLES cycles to reach FULL.
- An asynchronous reset mid-ramp or mid-period clears everything the same cycle. There is no partial-period output afterward.

## Configuration
- `LED_FADE_GAMMA_EN` defined:
  - `duty` is loaded with (level×level) >> PWM_BITS, which is perceptual square-law dimming.
  - The product is 2×(PWM_BITS+1) bits wide; the result fits PWM_BITS+1 bits.
  - Endpoints map 0→0 and FULL→FULL.
- `LED_FADE_GAMMA_EN` undefined: `duty` is loaded with level directly (linear).

## Structure
- Shared package `led_pkg` holds:
  - `LED_N` = 4.
  - `PL_CLK_HZ` = 50_000_000.
  - Default `PWM_BITS` / `STEP_CYCLES` constants.
- Sub-module `led_fade_channel`, instantiated LED_N times. Each instance holds one channel's target bit, level, duty (including the gamma option), led_out bit and mismatch flag.
- The top level owns the shared `pwm_cnt`, tick counter and `busy` OR.

## Test plan
Bench parameters: `PWM_BITS`=3 (FULL=8), `STEP_CYCLES`=4.
- **Reset:** assert `rst_n`=0 with `led_in`=4'b1111 → `led_out`=0 and `busy`=0 throughout reset and until the first duty load.
- **Fade in:** fade_en=1, `led_in` 0000→0001.
  - `busy` rises 1 cycle later.
  - level[0] reaches 8 after 8 ticks (32 cycles); `busy` then falls.
  - `led_out[0]` is constant 1 from the following period.
- **Snap:** fade_en=0, `led_in`=0100 → `busy` stays 0 and `led_out[2]` is constant 1 within 11 cycles.
- **Reversal:** fade_en=1, level[1]=3 and rising, `led_in[1]` drops → next tick level 2, then 1, then 0. No intermediate jump.
- **Duty shape:** hold level=4.
  - Without the macro, `led_out` is high for cycles 0–3 of each 8-cycle period.
  - With `LED_FADE_GAMMA_EN`, it is high for cycles 0–1 only.
- **Reset mid-ramp:** pulse `rst_n` low at level 5 → all outputs 0 in the same cycle; the ramp restarts from 0 after release.
